fifo_rd_drain: RTL and testbench

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 53 +++++
 rtl/fifo_rd_drain.sv | 74 +++++++
 tb/tb_fifo_rd_drain.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-drain block.
// Optional feature macro used by the block: FIFO_RD_STATS_EN (delivered-byte counter).
package fifo_rd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } drain_state_e;

  localparam int DATA_W_DEF   = 8;
  localparam int SKID_DEPTH_C = 2;
  localparam int CNT_W        = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head is always the oldest entry, tail the newer one.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_r,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        occ_q;

  always_ff @(posedge clk_r) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= din;
          else               tail_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          // head leaves while the new word lands behind whatever remains
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din;
          end else begin
            head_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = head_q;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains an external FIFO into a ready/valid stream through a 2-entry buffer.
// Optional delivered-byte counter rd_count is built only with FIFO_RD_STATS_EN.
//
//   state | meaning
//   IDLE  | no new FIFO reads; buffered/inflight data still offered
//   RUN   | reads issued whenever the buffer has room for them
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SKID_DEPTH = SKID_DEPTH_C
) (
  input  logic              clk_r,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_count
`endif
);

  localparam logic [2:0] DEPTH_L = 3'(SKID_DEPTH);

  drain_state_e state_q;
  logic         inflight_q;
  logic [1:0]   occ;
  logic         pop;
  logic [2:0]   committed;

  assign pop       = out_valid && out_ready;
  assign committed = {1'b0, occ} + {2'b00, inflight_q};

  // committed - pop < depth, rearranged so the 3-bit sum never underflows
  assign rd_en = !rst && (state_q == RUN) && !buf_empty &&
                 (committed < (DEPTH_L + {2'b00, pop}));

  always_ff @(posedge clk_r) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= drain_en ? RUN : IDLE;
      inflight_q <= rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_r (clk_r),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (buf_out),
    .dout  (out_data),
    .occ   (occ)
  );

  assign out_valid = (occ != 2'd0);

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk_r) begin
    if (rst)      rd_count <= '0;
    else if (pop) rd_count <= rd_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Randomised self-checking bench for fifo_rd_drain against a queue-based model.
module tb_fifo_rd_drain;
  import fifo_rd_pkg::*;

  logic       clk_r = 1'b0;
  logic       rst = 1'b1;
  logic       drain_en = 1'b0;
  logic       buf_empty = 1'b1;
  logic [7:0] buf_out = 8'h00;
  logic       rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count;
`endif

  always #5 clk_r = ~clk_r;

  fifo_rd_drain #(.DATA_W(8), .SKID_DEPTH(2)) dut (
    .clk_r     (clk_r),
    .rst       (rst),
    .drain_en  (drain_en),
    .buf_empty (buf_empty),
    .buf_out   (buf_out),
    .rd_en     (rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // external FIFO contents and the in-order list of bytes read but not yet delivered
  byte unsigned fifo_q[$];
  byte unsigned sb[$];
  logic gate = 1'b0;
  int   m_occ = 0, m_infl = 0, m_cnt = 0;
  logic m_run = 1'b0;
  int   cyc = 0, reads = 0, pops = 0, n_pushed = 0, stop_at = 0;
  int   first_rd_cyc, first_val_cyc, first_pop_cyc, last_pop_cyc;
  logic [7:0] first_pop_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    reads = 0; pops = 0; n_pushed = 0;
    first_rd_cyc = -1; first_val_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    first_pop_data = 8'h00;
  endtask

  task automatic fifo_push(input byte unsigned d);
    fifo_q.push_back(d);
    n_pushed++;
  endtask

  task automatic tick();
    logic exp_rd, mpop, acc;
    byte unsigned rdata;
    @(negedge clk_r);
    buf_empty = gate || (fifo_q.size() == 0);
    #1;
    mpop   = (m_occ > 0) && out_ready;
    exp_rd = !rst && m_run && !buf_empty && ((m_occ + m_infl - int'(mpop)) < 2);
    chk("rd_en", rd_en, exp_rd);
    chk("out_valid", out_valid, m_occ > 0);
    if (m_occ > 0 && sb.size() > 0) chk("out_data", out_data, sb[0]);
`ifdef FIFO_RD_STATS_EN
    chk("rd_count", rd_count, m_cnt & 32'hFFFF);
`endif
    acc = rd_en && !buf_empty;
    if (acc) begin
      reads++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (out_valid && out_ready) begin
      pops++;
      if (first_pop_cyc < 0) begin
        first_pop_cyc  = cyc;
        first_pop_data = out_data;
      end
      last_pop_cyc = cyc;
    end
    if (stop_at > 0 && reads >= stop_at) drain_en = 1'b0;
    @(posedge clk_r);
    #1;
    if (rst) begin
      fifo_q.delete(); sb.delete();
      m_occ = 0; m_infl = 0; m_run = 1'b0; m_cnt = 0;
      buf_out = 8'($urandom);
    end else begin
      if (mpop) begin
        if (sb.size() > 0) void'(sb.pop_front());
        m_cnt++;
      end
      m_occ = m_occ + m_infl - int'(mpop);
      m_run = drain_en;
      if (acc && fifo_q.size() > 0) begin
        rdata = fifo_q.pop_front();
        sb.push_back(rdata);
        buf_out = rdata;
      end else begin
        buf_out = 8'($urandom);
      end
      m_infl = acc ? 1 : 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; drain_en = 1'b0; out_ready = 1'b0; gate = 1'b0; stop_at = 0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_rd_en", rd_en, 1'b0);
    rst = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    gate = 1'b0; out_ready = 1'b1; drain_en = 1'b1; stop_at = 0;
    while ((fifo_q.size() != 0 || sb.size() != 0 || m_infl != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", n >= 60, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // preload three bytes, stream with out_ready high
    do_reset();
    clear_stats();
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    drain_en = 1'b1; out_ready = 1'b1;
    repeat (8) tick();
    chk("s1_pops", pops, 3);
    chk("s1_back_to_back", last_pop_cyc - first_pop_cyc, 2);
    chk("s1_latency", first_val_cyc - first_rd_cyc, 2);
    chk("s1_first", first_pop_data, 8'h11);

    // backpressure: only two reads while stalled, head held
    do_reset();
    clear_stats();
    for (int i = 0; i < 5; i++) fifo_push(8'(8'h51 + i));
    drain_en = 1'b1; out_ready = 1'b0;
    repeat (10) tick();
    chk("s2_reads_stalled", reads, 2);
    chk("s2_valid", out_valid, 1'b1);
    chk("s2_head", out_data, 8'h51);
    out_ready = 1'b1;
    repeat (12) tick();
    chk("s2_pops", pops, 5);

    // drain_en dropped in the cycle of the 2nd read, then resumed
    do_reset();
    clear_stats();
    for (int i = 0; i < 5; i++) fifo_push(8'(8'h61 + i));
    out_ready = 1'b1; drain_en = 1'b1; stop_at = 2;
    repeat (8) tick();
    chk("s3_reads_paused", reads, 2);
    chk("s3_pops_paused", pops, 2);
    stop_at = 0; drain_en = 1'b1; first_pop_cyc = -1;
    repeat (10) tick();
    chk("s3_resume_byte", first_pop_data, 8'h63);
    chk("s3_pops", pops, 5);

    // reset with data buffered and a read in flight
    do_reset();
    clear_stats();
    for (int i = 0; i < 8; i++) fifo_push(8'(8'h71 + i));
    drain_en = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!(m_infl == 1 && m_occ == 1) && n < 20) begin
      tick();
      n++;
    end
    chk("s4_reached_busy", n < 20, 1'b1);
    rst = 1'b1;
    tick();
    chk("s4_valid_after_rst", out_valid, 1'b0);
    tick();
    rst = 1'b0;
    clear_stats();
    fifo_push(8'hA0); fifo_push(8'hA1); fifo_push(8'hA2);
    repeat (10) tick();
    chk("s4_first_after_rst", first_pop_data, 8'hA0);
    chk("s4_pops", pops, 3);

    // random: buf_empty gated every other cycle, random ready and drain
    do_reset();
    clear_stats();
    for (int i = 0; i < 400; i++) begin
      gate      = cyc[0];
      out_ready = 1'($urandom);
      drain_en  = ($urandom_range(7) != 0);
      if (fifo_q.size() < 4 && $urandom_range(1) == 1) fifo_push(8'($urandom));
      tick();
    end
    settle();
    chk("s5_no_loss", pops, n_pushed);
    chk("s5_reads", reads, n_pushed);

`ifdef FIFO_RD_STATS_EN
    // counter wrap after 65537 deliveries
    do_reset();
    clear_stats();
    drain_en = 1'b1; out_ready = 1'b1;
    n = 0;
    while (m_cnt < 65537 && n < 70000) begin
      if (fifo_q.size() < 2) fifo_push(8'($urandom));
      if (m_cnt + m_occ >= 65537) out_ready = 1'b0;
      tick();
      n++;
    end
    out_ready = 1'b0;
    tick();
    chk("s6_wrap_count", rd_count, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
